// File: rtl/sdcard_sector_reader_if.sv
// Bus bundle between the sector reader, the firmware/SPI side and the IDE
// sector buffer. The reader itself attaches through the slave modport.
interface sdcard_sector_reader_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [7:0] token;
  logic       spi_active;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] sdcard_dma_data;
  logic [8:0] sdcard_dma_addr;
  logic       sdcard_dma_strobe;

  modport master (
    output start, spi_miso,
    input  busy, done, status, token, spi_active, spi_sck, spi_mosi,
           sdcard_dma_data, sdcard_dma_addr, sdcard_dma_strobe
  );

  modport slave (
    input  start, spi_miso,
    output busy, done, status, token, spi_active, spi_sck, spi_mosi,
           sdcard_dma_data, sdcard_dma_addr, sdcard_dma_strobe
  );
endinterface

// File: rtl/sdcard_sector_reader.sv
// SPI read engine: polls for the SD start token, streams 512 data bytes into
// the IDE sector buffer through the sdcard-DMA port and checks the CRC16.
module sdcard_sector_reader #(
  parameter int CLKDIV        = 1,
  parameter int TOKEN_TIMEOUT = 4095
) (
  input logic                   clk,
  input logic                   rst,
  sdcard_sector_reader_if.slave bus
);
  localparam int               DIV_W      = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKDIV - 1);
  localparam logic [11:0]      POLL_LIMIT = 12'(TOKEN_TIMEOUT);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADTOK  = 2'b10;
  localparam logic [1:0] ST_BADCRC  = 2'b11;

  typedef enum logic [2:0] {IDLE, TOKEN, DATA, CRC, FIN} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             sck;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [11:0]      poll_cnt;
  logic [15:0]      crc_calc;
  logic [15:0]      crc_rx;
  logic             crc_byte1;
  logic [8:0]       addr_cnt;
  logic [1:0]       status;
  logic [7:0]       token;
  logic [7:0]       dma_data;
  logic [8:0]       dma_addr;
  logic             dma_strobe;
  logic             running, tick, rise, byte_end;
  logic [15:0]      crc_rcvd;

  // CRC16-CCITT (poly 0x1021, MSB first, non-reflected), one bit per call
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ (((crc[15] ^ din) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  assign running  = (state == TOKEN) || (state == DATA) || (state == CRC);
  assign tick     = running && (div_cnt == DIV_LAST);
  assign rise     = tick && !sck;
  assign byte_end = tick && sck && (bit_cnt == 3'd7);
  // first CRC byte is already in crc_rx[7:0]; the second is still in shreg
  assign crc_rcvd = {crc_rx[7:0], shreg};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; every transition out of a busy state happens on a byte boundary
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.start) state_next = TOKEN;
      TOKEN: if (byte_end) begin
               if (shreg == 8'hFE)                       state_next = DATA;
               else if (shreg != 8'hFF)                  state_next = FIN;
               else if ((poll_cnt + 12'd1) == POLL_LIMIT) state_next = FIN;
             end
      DATA:  if (byte_end && (addr_cnt == 9'd511)) state_next = CRC;
      CRC:   if (byte_end && crc_byte1) state_next = FIN;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SCK generator: CLKDIV cycles low then CLKDIV high per bit, held low when idle
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      sck     <= !sck;
      if (sck) bit_cnt <= bit_cnt + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // MISO shift-in on the low-to-high SCK transition, MSB first
  always_ff @(posedge clk) begin
    if (rise) shreg <= {shreg[6:0], bus.spi_miso};
  end

  // Running CRC over data-phase bits, and capture of the two trailing CRC bytes
  always_ff @(posedge clk) begin
    if ((state == IDLE) && bus.start) crc_calc <= 16'h0000;
    else if ((state == DATA) && rise) crc_calc <= crc16_step(crc_calc, bus.spi_miso);
    if ((state == CRC) && byte_end) crc_rx <= {crc_rx[7:0], shreg};
  end

  // Transfer bookkeeping: poll counter, token, DMA write port and result status
  always_ff @(posedge clk) begin
    if (rst) begin
      status     <= ST_OK;
      token      <= 8'h00;
      dma_data   <= 8'h00;
      dma_addr   <= 9'd0;
      dma_strobe <= 1'b0;
      poll_cnt   <= 12'd0;
      addr_cnt   <= 9'd0;
      crc_byte1  <= 1'b0;
    end else begin
      dma_strobe <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          status    <= ST_OK;
          poll_cnt  <= 12'd0;
          addr_cnt  <= 9'd0;
          crc_byte1 <= 1'b0;
        end
        TOKEN: if (byte_end) begin
          token <= shreg;
          if (shreg == 8'hFF) begin
            poll_cnt <= poll_cnt + 12'd1;
            if ((poll_cnt + 12'd1) == POLL_LIMIT) status <= ST_TIMEOUT;
          end else if (shreg != 8'hFE) begin
            status <= ST_BADTOK;
          end
        end
        DATA: if (byte_end) begin
          dma_strobe <= 1'b1;
          dma_data   <= shreg;
          dma_addr   <= addr_cnt;
          addr_cnt   <= addr_cnt + 9'd1;
        end
        CRC: if (byte_end) begin
          crc_byte1 <= 1'b1;
          if (crc_byte1) status <= (crc_rcvd == crc_calc) ? ST_OK : ST_BADCRC;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy              = running;
  assign bus.spi_active        = running;
  assign bus.done              = (state == FIN);
  assign bus.status            = status;
  assign bus.token             = token;
  assign bus.spi_sck           = sck;
  assign bus.spi_mosi          = 1'b1;
  assign bus.sdcard_dma_data   = dma_data;
  assign bus.sdcard_dma_addr   = dma_addr;
  assign bus.sdcard_dma_strobe = dma_strobe;
endmodule

// File: doc/sdcard_sector_reader.md
# sdcard_sector_reader

SPI read engine that streams one 512-byte SD card data block into the IDE sector buffer. The AVR firmware issues CMD17 over the shared SPI bus, then pulses `start`. The block then takes over the SPI clock and does the following:
- polls for the start token;
- shifts in 512 data bytes;
- presents each byte on the `sdcard_dma_data` / `sdcard_dma_addr` / `sdcard_dma_strobe` port of the IDE interface, which must be in sdcard-DMA buffer mode;
- receives and checks the CRC16.

## Interface
- `CLKDIV`, default 1: SCK half-period in `clk` cycles (≥1).
- `TOKEN_TIMEOUT`, default 4095: maximum number of 0xFF bytes polled before a timeout error (≥1, 12-bit counter).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to begin; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a transfer (success or error).
- `status`  out  2  result, valid from `done` until the next `start`: 00 ok, 01 token timeout, 10 bad token, 11 CRC mismatch.
- `token`  out  8  last byte received in token phase; for diagnostics.
- `spi_active`  out  1  equals `busy`; selects this block on the SCK/MOSI mux.
- `spi_sck`  out  1  SPI clock, mode 0, idle low.
- `spi_mosi`  out  1  constant 1.
- `spi_miso`  in  1  SPI data from the card, already synchronised.
- `sdcard_dma_data`  out  8  received byte.
- `sdcard_dma_addr`  out  9  byte index 0..511.
- `sdcard_dma_strobe`  out  1  one-cycle write strobe.

## Operation
- FSM states: IDLE → TOKEN → DATA → CRC → FIN → IDLE.
- Byte engine, per bit:
  - SCK low for `CLKDIV` cycles, then high for `CLKDIV` cycles.
  - MISO is sampled on the cycle SCK goes high, MSB first.
  - A byte completes when the 8th high phase ends; SCK is then low.
  - Bytes are back-to-back with no idle gap.
- IDLE: on `start`, clear the poll counter, CRC (init 0x0000), address, and `status`; go to TOKEN.
- TOKEN: receive one byte; latch it into `token`.
  - 0xFE → DATA.
  - 0xFF → increment the poll counter. When the counter reaches `TOKEN_TIMEOUT`, set status 01 and go to FIN; otherwise receive again.
  - Any other value → status 10, FIN.
- DATA:
  - Each sampled bit is fed into CRC16-CCITT, poly 0x1021, non-reflected.
  - On each byte completion, emit the strobe, then increment the address.
  - After byte 511 → CRC.
- CRC: receive 2 bytes (MSB byte first) into a 16-bit register. These bytes are not fed into the CRC. Compare the received value against the computed CRC: mismatch → status 11, else 00. Then go to FIN.
- FIN: pulse `done`, drop `busy`, go to IDLE.
- `start` while busy: no effect.
- `rst` mid-transfer: in the next cycle, state IDLE, SCK low, strobe low. No `done` pulse; the partial buffer contents are left as written.
- Address arithmetic: 9-bit; it wraps to 0 after 511, which is only reached on exit from DATA.

## Timing
- Reset values:
  - `busy`, `done`, `spi_active`, `spi_sck`, `sdcard_dma_strobe` = 0.
  - `spi_mosi` = 1.
  - `status` = 00; `token` = 0x00; `sdcard_dma_data` = 0x00; `sdcard_dma_addr` = 0.
- `start` accepted in cycle T → `busy` = 1 at T+1; first SCK rise at T+1+`CLKDIV`.
- One byte takes 16·`CLKDIV` cycles; with `CLKDIV`=1, a full data phase is 8192 cycles.
- Strobe:
  - `sdcard_dma_strobe` is high for exactly 1 cycle, at the first cycle after the byte's 8th high phase ends.
  - Data and address are valid in the strobe cycle and held until the next strobe.
  - Consecutive strobes are 16·`CLKDIV` cycles apart.
- `done` asserts in the cycle after the final byte (token or CRC) completes; `busy` = 0 in the same cycle as `done`.
- Successful transfer with an immediate token, `CLKDIV`=1: `done` at T+1+16·515.

## Test plan
- Card model returns 0xFF ×3, then 0xFE, 512×0xFF, CRC 0x7FA1 → 512 strobes, addr 0..511, data 0xFF, `status` 00, `done` once, `token` 0xFE.
- Data byte i = i[7:0], correct CRC computed by the bench model, `CLKDIV`=3 → strobe spacing 48 cycles, data matches, `status` 00.
- MISO stuck high, `TOKEN_TIMEOUT`=10 → `done` after exactly 10 token bytes, `status` 01, zero strobes.
- Token 0x05 → `status` 10, `token` 0x05, zero strobes.
- 512×0xFF with CRC 0x0000 → 512 strobes, `status` 11.
- `rst` asserted at byte 100 → next cycle SCK 0, `busy` 0, no `done`; `start` pulsed during busy → ignored; a new `start` after reset completes normally with `status` 00.
